// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared types and constants for the L1 data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_cache_pkg;

   localparam int BLOCK_BYTES     = 16;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int BLOCK_BITS      = BLOCK_BYTES * 8;
   localparam int WORD_BITS       = BLOCK_BITS / WORDS_PER_BLOCK;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   // Load funct3 codes (cpu_read[2:0]).
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store size codes (cpu_write[1:0]).
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: CPU-side and memory-side signal bundle of the data cache.
// Latency: n/a (wires only).
// Backpressure: busywait toward the CPU, mem_busywait from main memory.
interface data_cache_if;

   logic [31:0]  cpu_addr;
   logic [31:0]  cpu_write_data;
   logic [3:0]   cpu_read;
   logic [2:0]   cpu_write;
   logic [31:0]  cpu_read_data;
   logic         busywait;

   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_address;
   logic [127:0] mem_write_data;
   logic [127:0] mem_read_data;
   logic         mem_busywait;

   // Cache view.
   modport slave (
      input  cpu_addr, cpu_write_data, cpu_read, cpu_write,
      input  mem_read_data, mem_busywait,
      output cpu_read_data, busywait,
      output mem_read, mem_write, mem_address, mem_write_data
   );

   // CPU + memory view.
   modport master (
      output cpu_addr, cpu_write_data, cpu_read, cpu_write,
      output mem_read_data, mem_busywait,
      input  cpu_read_data, busywait,
      input  mem_read, mem_write, mem_address, mem_write_data
   );

endinterface

// File: rtl/data_cache_load_store_align.sv
// load_store_align: byte/half/word extraction with sign/zero extension, and store lane merge.
// Latency: purely combinational.
// Backpressure: none; operates on whatever word the cache presents.
module load_store_align
   import data_cache_pkg::*;
(
   input  logic [31:0] word_dat,
   input  logic [1:0]  byte_sel,
   input  logic [2:0]  funct3,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_dat,
   output logic [31:0] ld_dat,
   output logic [31:0] st_word
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [3:0]  st_be;
   logic [31:0] st_lanes;

   // Halfword accesses look only at addr[1]; misalignment is silently tolerated.
   assign ld_byte = word_dat[{byte_sel, 3'b000} +: 8];
   assign ld_half = byte_sel[1] ? word_dat[31:16] : word_dat[15:0];

   // Select and extend the load result; unknown funct3 yields zero.
   always_comb begin
      ld_dat = '0;
      case (funct3)
         F3_LB:   ld_dat = {{24{ld_byte[7]}}, ld_byte};
         F3_LH:   ld_dat = {{16{ld_half[15]}}, ld_half};
         F3_LW:   ld_dat = word_dat;
         F3_LBU:  ld_dat = {24'd0, ld_byte};
         F3_LHU:  ld_dat = {16'd0, ld_half};
         default: ld_dat = '0;
      endcase
   end

   // Byte enables and replicated store lanes; an undefined size writes nothing.
   always_comb begin
      st_be    = 4'b0000;
      st_lanes = '0;
      case (st_size)
         SZ_B: begin
            st_be    = 4'b0001 << byte_sel;
            st_lanes = {4{st_dat[7:0]}};
         end
         SZ_H: begin
            st_be    = byte_sel[1] ? 4'b1100 : 4'b0011;
            st_lanes = {2{st_dat[15:0]}};
         end
         SZ_W: begin
            st_be    = 4'b1111;
            st_lanes = st_dat;
         end
         default: st_be = 4'b0000;
      endcase
   end

   // Merge enabled lanes over the currently stored word.
   always_comb begin
      st_word = word_dat;
      for (int b = 0; b < 4; b++) begin
         if (st_be[b]) st_word[b*8 +: 8] = st_lanes[b*8 +: 8];
      end
   end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate L1 D-cache, 16-byte blocks (DCACHE_STATS_EN adds hit/miss counters).
// Latency: hits answer combinationally with zero stall; a clean miss stalls 1 + memory latency + 1 cycles, a dirty miss adds a writeback.
// Backpressure: busywait holds the CPU while missing; each block transfer waits for mem_busywait to fall.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 28 - INDEX_BITS
) (
   input  logic        CLK,
   input  logic        RST,
   data_cache_if.slave bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int BLOCKS = 1 << INDEX_BITS;

   logic [BLOCK_BITS-1:0] data_arr [BLOCKS];
   logic [TAG_BITS-1:0]   tag_arr  [BLOCKS];
   logic [BLOCKS-1:0]     valid;
   logic [BLOCKS-1:0]     dirty;
   logic [BLOCK_BITS-1:0] fill_buf;

   state_t state;
   state_t state_nxt;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic [1:0]            word_sel;
   logic                  req;
   logic                  is_store;
   logic                  hit;
   logic                  idle_hit;
   logic                  wr_hit;
   logic                  miss_start;
   logic [BLOCK_BITS-1:0] blk;
   logic [31:0]           cur_word;
   logic [31:0]           ld_dat;
   logic [31:0]           st_word;

   assign idx      = bus.cpu_addr[3+INDEX_BITS:4];
   assign tag      = bus.cpu_addr[31:4+INDEX_BITS];
   assign word_sel = bus.cpu_addr[3:2];

   // A simultaneous load+store is serviced as a store; the load data is still shown.
   assign req      = bus.cpu_read[3] | bus.cpu_write[2];
   assign is_store = bus.cpu_write[2];
   assign hit      = valid[idx] && (tag_arr[idx] == tag);

   assign idle_hit   = (state == IDLE) && req && hit;
   assign wr_hit     = idle_hit && is_store;
   assign miss_start = (state == IDLE) && req && !hit;

   assign blk      = data_arr[idx];
   assign cur_word = blk[{word_sel, 5'b00000} +: WORD_BITS];

   load_store_align u_align (
      .word_dat (cur_word),
      .byte_sel (bus.cpu_addr[1:0]),
      .funct3   (bus.cpu_read[2:0]),
      .st_size  (bus.cpu_write[1:0]),
      .st_dat   (bus.cpu_write_data),
      .ld_dat   (ld_dat),
      .st_word  (st_word)
   );

   // Stall is combinational on a miss so the CPU freezes in the request cycle.
   assign bus.busywait      = (state != IDLE) || miss_start;
   assign bus.cpu_read_data = ((state == IDLE) && bus.cpu_read[3] && hit) ? ld_dat : '0;

   // Miss-handling state register.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state plus Moore decode of the memory request; read and write are exclusive by state.
   always_comb begin
      state_nxt          = state;
      bus.mem_read       = 1'b0;
      bus.mem_write      = 1'b0;
      bus.mem_address    = '0;
      bus.mem_write_data = '0;
      case (state)
         IDLE: begin
            if (miss_start) state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            bus.mem_write      = 1'b1;
            bus.mem_address    = {tag_arr[idx], idx};
            bus.mem_write_data = blk;
            if (!bus.mem_busywait) state_nxt = ALLOCATE;
         end
         ALLOCATE: begin
            bus.mem_read    = 1'b1;
            bus.mem_address = {tag, idx};
            if (!bus.mem_busywait) state_nxt = UPDATE;
         end
         UPDATE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Hold the refill block from the cycle memory completes until UPDATE installs it.
   always_ff @(posedge CLK) begin
      if ((state == ALLOCATE) && !bus.mem_busywait) fill_buf <= bus.mem_read_data;
   end

   // Valid/dirty bookkeeping; the only per-block state that reset clears.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid <= '0;
         dirty <= '0;
      end else if (state == UPDATE) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (wr_hit) begin
         dirty[idx] <= 1'b1;
      end
   end

   // Block data and tags; left unreset since valid gates every use.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (state == UPDATE) begin
            data_arr[idx] <= fill_buf;
            tag_arr[idx]  <= tag;
         end else if (wr_hit) begin
            data_arr[idx][{word_sel, 5'b00000} +: WORD_BITS] <= st_word;
         end
      end
   end

`ifdef DCACHE_STATS_EN
   // retry flags the IDLE re-evaluation right after a refill so it is not counted as a hit.
   logic retry;

   // Hit/miss counters, wrapping naturally at 2^32.
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
         retry      <= 1'b0;
      end else begin
         if (state == UPDATE)    retry <= 1'b1;
         else if (state == IDLE) retry <= 1'b0;
         if (idle_hit && !retry) hit_count  <= hit_count + 32'd1;
         if (miss_start)         miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: scoreboard bench for data_cache against a fixed-latency block memory.
// Latency: memory completes a transfer after LAT cycles of request.
// Backpressure: CPU side holds each request until busywait drops.
module tb_data_cache;
   import data_cache_pkg::*;

   localparam int LAT = 5;
   localparam logic [3:0] RD_NONE = 4'b0000;
   localparam logic [3:0] RD_LB   = {1'b1, F3_LB};
   localparam logic [3:0] RD_LH   = {1'b1, F3_LH};
   localparam logic [3:0] RD_LW   = {1'b1, F3_LW};
   localparam logic [3:0] RD_LBU  = {1'b1, F3_LBU};
   localparam logic [3:0] RD_LHU  = {1'b1, F3_LHU};
   localparam logic [2:0] WR_NONE = 3'b000;
   localparam logic [2:0] WR_SB   = {1'b1, SZ_B};
   localparam logic [2:0] WR_SH   = {1'b1, SZ_H};
   localparam logic [2:0] WR_SW   = {1'b1, SZ_W};

   logic clk = 1'b0;
   logic rst;
   logic mem_init;

   data_cache_if dbus ();

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   data_cache u_dut (
      .CLK (clk),
      .RST (rst),
      .bus (dbus)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial forever #5 clk = ~clk;

   // Initial memory image: block 4 holds the known pattern, others encode their address.
   function automatic logic [127:0] blk_init(input logic [5:0] a);
      logic [127:0] b;
      b = '0;
      if (a == 6'd4) b = {32'h55667788, 32'h11223344, 32'h8081F2F3, 32'hDEADBEEF};
      else for (int w = 0; w < 4; w++) b[w*32 +: 32] = {4'hB, 18'd0, a, 2'd0, 2'(w)};
      return b;
   endfunction

   // Main memory model: busy for LAT-1 cycles of a request, completes on the LAT-th.
   logic [127:0] mem_arr [64];
   logic [3:0]   mcnt;
   logic         mreq;
   assign mreq               = dbus.mem_read | dbus.mem_write;
   assign dbus.mem_busywait  = mreq && (mcnt < 4'(LAT - 1));
   assign dbus.mem_read_data = dbus.mem_read ? mem_arr[dbus.mem_address[5:0]] : '0;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem_arr[i] <= blk_init(6'(i));
         mcnt <= '0;
      end else begin
         if (mreq && !dbus.mem_busywait && dbus.mem_write)
            mem_arr[dbus.mem_address[5:0]] <= dbus.mem_write_data;
         if (mreq && dbus.mem_busywait) mcnt <= mcnt + 4'd1;
         else                           mcnt <= '0;
      end
   end

   // Memory-side monitor: cycle counts and last seen addresses/data.
   int          rd_cyc, wr_cyc, both_cyc;
   logic [27:0] rd_addr, wr_addr;
   logic [31:0] wr_w0;
   always @(negedge clk) begin
      if (mem_init) begin
         rd_cyc   <= 0;
         wr_cyc   <= 0;
         both_cyc <= 0;
      end else begin
         if (dbus.mem_read) begin
            rd_cyc  <= rd_cyc + 1;
            rd_addr <= dbus.mem_address;
         end
         if (dbus.mem_write) begin
            wr_cyc  <= wr_cyc + 1;
            wr_addr <= dbus.mem_address;
            wr_w0   <= dbus.mem_write_data[31:0];
         end
         if (dbus.mem_read && dbus.mem_write) both_cyc <= both_cyc + 1;
      end
   end

   int total = 0;
   int bad   = 0;
   logic [31:0] sb [$];
   int d_rd, d_wr, d_both;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic idle_cpu();
      dbus.cpu_addr       = '0;
      dbus.cpu_write_data = '0;
      dbus.cpu_read       = RD_NONE;
      dbus.cpu_write      = WR_NONE;
   endtask

   // One CPU access: held until busywait drops, then load data and stall length are checked.
   task automatic access(input string tag, input logic [31:0] a, input logic [3:0] rd,
                         input logic [2:0] wr, input logic [31:0] wd,
                         input logic [31:0] exp_dat, input int exp_stall);
      int stall;
      int rd0, wr0, both0;
      logic [31:0] e;
      stall = 0;
      @(negedge clk);
      dbus.cpu_addr       = a;
      dbus.cpu_read       = rd;
      dbus.cpu_write      = wr;
      dbus.cpu_write_data = wd;
      if (rd[3]) sb.push_back(exp_dat);
      #1;
      rd0 = rd_cyc; wr0 = wr_cyc; both0 = both_cyc;
      while (dbus.busywait && stall < 200) begin
         @(negedge clk);
         #1;
         stall++;
      end
      chk({tag, ":busy"}, {31'd0, dbus.busywait}, 32'd0);
      if (rd[3]) begin
         e = sb.pop_front();
         chk({tag, ":data"}, dbus.cpu_read_data, e);
      end
      chk({tag, ":stall"}, stall, exp_stall);
      d_rd   = rd_cyc - rd0;
      d_wr   = wr_cyc - wr0;
      d_both = both_cyc - both0;
      @(posedge clk);
      #1;
      idle_cpu();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle_cpu();
      mem_init = 1'b1;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_init = 1'b0;
      rst      = 1'b0;
      #1;
      chk("rst_busywait", {31'd0, dbus.busywait}, 32'd0);
      chk("rst_mem_read", {31'd0, dbus.mem_read}, 32'd0);
      chk("rst_mem_write", {31'd0, dbus.mem_write}, 32'd0);
      chk("rst_rdata", dbus.cpu_read_data, 32'd0);

      // Cold miss then immediate zero-stall repeat.
      access("cold_lw", 32'h40, RD_LW, WR_NONE, 0, 32'hDEADBEEF, 1 + LAT + 1);
      chk("cold_rd_cycles", d_rd, LAT);
      chk("cold_wr_cycles", d_wr, 0);
      chk("cold_rd_addr", {4'd0, rd_addr}, 32'h4);
      access("warm_lw", 32'h40, RD_LW, WR_NONE, 0, 32'hDEADBEEF, 0);

      // Sign and zero extension on word 1 = 0x8081F2F3.
      access("lb",   32'h44, RD_LB,  WR_NONE, 0, 32'hFFFFFFF3, 0);
      access("lbu",  32'h44, RD_LBU, WR_NONE, 0, 32'h000000F3, 0);
      access("lh",   32'h46, RD_LH,  WR_NONE, 0, 32'hFFFF8081, 0);
      access("lhu",  32'h46, RD_LHU, WR_NONE, 0, 32'h00008081, 0);
      access("lb3",  32'h47, RD_LB,  WR_NONE, 0, 32'hFFFFFF80, 0);
      access("lh0",  32'h44, RD_LH,  WR_NONE, 0, 32'hFFFFF2F3, 0);

      // Write hits: byte, upper half, and a combined load+store.
      access("sb",     32'h40, RD_NONE, WR_SB, 32'h000000AA, 0, 0);
      access("lw_sb",  32'h40, RD_LW, WR_NONE, 0, 32'hDEADBEAA, 0);
      access("sh",     32'h4A, RD_NONE, WR_SH, 32'h00001234, 0, 0);
      access("lw_sh",  32'h48, RD_LW, WR_NONE, 0, 32'h12343344, 0);
      access("ld_st",  32'h4C, RD_LW, WR_SW, 32'hCAFEF00D, 32'h55667788, 0);
      access("lw_sw",  32'h4C, RD_LW, WR_NONE, 0, 32'hCAFEF00D, 0);

      // No request: no stall, zero read data even on a resident line.
      @(negedge clk);
      dbus.cpu_addr = 32'h40;
      #1;
      chk("noreq_rdata", dbus.cpu_read_data, 32'd0);
      chk("noreq_busy", {31'd0, dbus.busywait}, 32'd0);
      idle_cpu();

      // Dirty eviction: index 4 with a new tag.
      access("evict", 32'hC0, RD_LW, WR_NONE, 0, 32'hB00000C0, 1 + LAT + LAT + 1);
      chk("evict_wr_cycles", d_wr, LAT);
      chk("evict_rd_cycles", d_rd, LAT);
      chk("evict_overlap", d_both, 0);
      chk("evict_wr_addr", {4'd0, wr_addr}, 32'h4);
      chk("evict_wr_w0", wr_w0, 32'hDEADBEAA);
      chk("evict_rd_addr", {4'd0, rd_addr}, 32'hC);

      // Clean miss: no writeback; data comes back from the written-back block.
      access("clean", 32'h4C, RD_LW, WR_NONE, 0, 32'hCAFEF00D, 1 + LAT + 1);
      chk("clean_wr_cycles", d_wr, 0);
      chk("clean_rd_cycles", d_rd, LAT);

      // Reset in the middle of a refill.
      @(negedge clk);
      dbus.cpu_addr = 32'h1C0;
      dbus.cpu_read = RD_LW;
      repeat (3) @(negedge clk);
      #1;
      chk("rstmid_pre_rd", {31'd0, dbus.mem_read}, 32'd1);
      rst = 1'b1;
      idle_cpu();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstmid_mem_read", {31'd0, dbus.mem_read}, 32'd0);
      chk("rstmid_mem_write", {31'd0, dbus.mem_write}, 32'd0);
      chk("rstmid_busy", {31'd0, dbus.busywait}, 32'd0);
`ifdef DCACHE_STATS_EN
      chk("rstmid_hits", hit_count, 32'd0);
      chk("rstmid_misses", miss_count, 32'd0);
`endif

      // miss, hit, hit, miss after reset.
      access("re_miss", 32'h1C0, RD_LW, WR_NONE, 0, 32'hB00001C0, 1 + LAT + 1);
      chk("re_miss_rd_addr", {4'd0, rd_addr}, 32'h1C);
      access("re_hit1", 32'h1C4, RD_LW, WR_NONE, 0, 32'hB00001C1, 0);
      access("re_hit2", 32'h1C8, RD_LW, WR_NONE, 0, 32'hB00001C2, 0);
      access("re_miss2", 32'h40, RD_LW, WR_NONE, 0, 32'hDEADBEAA, 1 + LAT + 1);
      chk("re_miss2_wr_cycles", d_wr, 0);
`ifdef DCACHE_STATS_EN
      chk("stats_hits", hit_count, 32'd2);
      chk("stats_misses", miss_count, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU memory-access stage and main data memory.
- Consumes the MA-stage address, write data and read/write controls; returns load data and a busywait stall.
- Busywait stalls the PC and all pipeline registers.
- Issues whole-block refill and writeback transfers to main memory over a busywait handshake.

Parameters:
- INDEX_BITS, 3, log2 of block count (8 blocks); TAG_BITS = 28 - INDEX_BITS.
- Block size is fixed at 16 bytes (4 words); offset = addr[3:0].

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous active-high reset
- cpu_addr  input  32  byte address from MA stage
- cpu_write_data  input  32  store data (rs2 value)
- cpu_read  input  4  [3]=load enable, [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- cpu_write  input  3  [2]=store enable, [1:0]=size (00 SB, 01 SH, 10 SW)
- cpu_read_data  output  32  extended load result
- busywait  output  1  CPU stall request
- mem_read  output  1  block refill request
- mem_write  output  1  block writeback request
- mem_address  output  28  block address {tag,index}
- mem_write_data  output  128  victim block, word0 in [31:0]
- mem_read_data  input  128  refill block, word0 in [31:0]
- mem_busywait  input  1  main memory busy; transfer complete when it falls

Behaviour:
- Reset, sampled at posedge RST=1:
  - Clear all valid and dirty bits; state=IDLE.
  - mem_read=0, mem_write=0, busywait=0, cpu_read_data=0.
  - Data and tag arrays are not cleared.
- Request definition: req = cpu_read[3] | cpu_write[2].
  - If both enables are set, the request is treated as a store; cpu_read_data is still driven for the load.
- Hit: valid[index] && tag[index]==addr[31:4+INDEX_BITS].
- Address fields: index = addr[3+INDEX_BITS:4]; word = addr[3:2]; byte = addr[1:0].
  - LH/SH use addr[1] only; LW/SW ignore addr[1:0]. Misalignment is never trapped.
- Read hit (IDLE):
  - cpu_read_data is combinational the same cycle; busywait=0; zero stall.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Write hit (IDLE):
  - busywait=0; selected bytes written at the next posedge; dirty[index] set.
- Miss (IDLE with req and !hit):
  - busywait=1 combinationally in the same cycle.
  - Next state is WRITEBACK if valid&&dirty, else ALLOCATE.
- States (busywait=1 in every state except IDLE):
  - IDLE: no memory request.
  - WRITEBACK: mem_write=1, mem_address={stored tag,index}, mem_write_data=block. Stays while mem_busywait=1; on the cycle mem_busywait=0, goes to ALLOCATE.
  - ALLOCATE: mem_read=1, mem_address={addr tag,index}. On mem_busywait=0, goes to UPDATE.
  - UPDATE: write mem_read_data into the block, set tag, valid=1, dirty=0; go to IDLE.
- After UPDATE the request re-evaluates in IDLE as a hit. Minimum miss penalty (clean): 1 + memory latency + 1 cycles.
- mem_read and mem_write are never asserted together; outputs are registered-state decoded (Moore).
- No request (req=0): busywait=0; no state change; cpu_read_data=0.
- Reset mid-miss: state returns to IDLE next edge and memory requests drop; in-flight dirty data is lost (accepted).
- The CPU must hold address, data and controls stable while busywait=1.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both cleared by RST.
  - hit_count increments once per serviced request that hits in IDLE on first evaluation.
  - miss_count increments once per IDLE→WRITEBACK/ALLOCATE transition.
  - A request retried after UPDATE is not counted again; counters wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package data_cache_pkg:
  - state enum (IDLE, WRITEBACK, ALLOCATE, UPDATE)
  - funct3 load codes and store size codes
  - BLOCK_BYTES=16, WORDS_PER_BLOCK=4
- One sub-module, load_store_align:
  - Combinational extraction and sign/zero extension for loads.
  - Byte-enable and data-lane merge for stores.
- The FSM and arrays stay in data_cache.

Test Plan:
- Cold read: after reset, LW 0x0000_0040 with memory block word0=0xDEADBEEF, 5-cycle memory latency → busywait high from request cycle, mem_read=1 with mem_address=0x0000004; cpu_read_data=0xDEADBEEF once busywait falls; immediate repeat LW has zero stall.
- Byte/half extension: block word=0x8081_F2F3 → LB addr+0 returns 0xFFFFFFF3, LBU returns 0x000000F3, LH addr+2 returns 0xFFFF8081, LHU returns 0x00008081.
- Write hit then dirty eviction:
  - SB 0xAA to 0x40 (hit) → no stall; dirty set.
  - LW 0x0000_00C0 (same index 4, new tag) → WRITEBACK with mem_address=0x0000004 and word0 byte0=0xAA, then ALLOCATE mem_address=0x000000C, mem_write never overlapping mem_read.
- Clean miss skips WRITEBACK: read conflicting clean block → mem_write stays 0 throughout.
- Reset in ALLOCATE: assert RST one cycle mid-refill → next cycle mem_read=0, busywait=0; the same address then misses again.
- DCACHE_STATS_EN: sequence of miss, hit, hit, miss → hit_count=2, miss_count=2.
